pe_rr_arbiter: RTL and testbench

Sequential 16-requester arbiter for one shared resource. Arbitration uses the team's 16:4 priority-encode rule: the highest set index wins. A rotating mask turns this into round-robin between grants. The block holds each grant until the owner releases it or a hold timeout expires, and drives one-hot and encoded grant outputs to the shared datapath mux.

---
 rtl/pe_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_pe_rr_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pe_rr_arbiter.sv
// Round-robin arbiter for one shared resource across 16 requesters.
// Highest-index-wins encoding with a rotating mask, hold timeout and a one-cycle switch-over bubble.
module pe_rr_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;
    logic [15:0]        gnt_q, gnt_d;
    logic [3:0]         gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [15:0]        below_mask;
    logic [15:0]        masked_req;
    logic [3:0]         masked_id;
    logic [3:0]         req_id;
    logic [3:0]         win_id;
    logic [15:0]        win_onehot;
    logic               owner_req;
    logic               hold_expired;

    // Later iterations override earlier ones, so the highest set index wins.
    function automatic logic [3:0] highest_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign below_mask = (16'h0001 << ptr_q) - 16'h0001;
    assign masked_req = req & below_mask;
    assign masked_id  = highest_idx(masked_req);
    assign req_id     = highest_idx(req);
    assign win_id     = (masked_req != 16'h0000) ? masked_id : req_id;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == 4'(gi));
        end
    endgenerate

    assign owner_req    = req[gnt_id_q];
    assign hold_expired = HOLD_EN && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 16'h0000) begin
                    state_d     = GRANT;
                    gnt_d       = win_onehot;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    ptr_d       = win_id;
                    cnt_d       = '0;
                end else begin
                    gnt_d       = 16'h0000;
                    gnt_id_d    = 4'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Priority order done > withdrawal > timeout keeps the pulse exclusive.
                if (done || !owner_req || hold_expired) begin
                    state_d     = IDLE;
                    gnt_d       = 16'h0000;
                    gnt_id_d    = 4'd0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    timeout_d   = !done && owner_req;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 16'h0000;
                gnt_id_d    = 4'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 4'd0;
            cnt_q       <= '0;
            gnt_q       <= 16'h0000;
            gnt_id_q    <= 4'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign busy      = gnt_valid_q;

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// Directed bench for pe_rr_arbiter (MAX_HOLD=4): per-cycle expectations are queued
// as stimulus is driven and popped for comparison after each rising edge.
module tb_pe_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } exp_t;

    exp_t sb_q[$];

    pe_rr_arbiter #(
        .MAX_HOLD(4),
        .HOLD_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, queue the expected post-edge outputs, compare after the edge.
    task automatic cyc(input string tag, input logic [15:0] r, input logic d, input logic rn,
                       input logic ev, input logic [3:0] eid, input logic eto);
        exp_t        e;
        exp_t        p;
        logic [15:0] eg;
        logic [22:0] obs;
        req   = r;
        done  = d;
        rst_n = rn;
        eg    = ev ? (16'h0001 << eid) : 16'h0000;
        e.tag = tag;
        e.exp = {eg, (ev ? eid : 4'd0), ev, eto, ev};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        p   = sb_q.pop_front();
        obs = {gnt, gnt_id, gnt_valid, timeout, busy};
        tests_run++;
        assert (obs === p.exp) else begin
            tests_failed++;
            $error("FAIL %s observed gnt/id/v/to/busy=%h required=%h", p.tag, obs, p.exp);
        end
        $display("[TB] %s req=%h done=%b rst_n=%b -> gnt=%h id=%0d v=%b to=%b",
                 p.tag, r, d, rn, gnt, gnt_id, gnt_valid, timeout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req   = 16'h0000;
        done  = 1'b0;
        rst_n = 1'b0;

        // Reset state
        cyc("reset0", 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("reset1", 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // All requesting: descending order with wrap, one bubble between grants
        for (int k = 15; k >= 0; k--) begin
            cyc("rr_grant", 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'(k), 1'b0);
            cyc("rr_bubble", 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        end
        cyc("rr_wrap15", 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        cyc("rr_wrap_rel", 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // No requests
        for (int k = 0; k < 20; k++) begin
            cyc("idle", 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        end

        // Hold timeout: 4 grant cycles, pulse at release, regrant after bubble
        cyc("to_grant", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc("to_hold", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        end
        cyc("to_release", 16'h0010, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc("to_regrant", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        cyc("to_done", 16'h0010, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Withdrawal of owner 9 while 3 requests
        cyc("wd_grant9", 16'h0200, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        cyc("wd_other_req", 16'h0208, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        cyc("wd_release", 16'h0008, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("wd_grant3", 16'h0008, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        cyc("wd_done", 16'h0008, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // done coincides with the timeout edge: no pulse
        cyc("co_grant", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc("co_hold", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        end
        cyc("co_release", 16'h0010, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("co_regrant", 16'h0010, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        cyc("co_done", 16'h0010, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset mid-grant: ptr returns to 0 so 15 wins over 0
        cyc("mr_grant15", 16'h8000, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        cyc("mr_hold", 16'h8001, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        cyc("mr_reset", 16'h8001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("mr_grant_after", 16'h8001, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        cyc("mr_done", 16'h8001, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("mr_grant0", 16'h8001, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
